// File: rtl/io_bank_ctrl.sv
// N-channel pad-bank controller: per-channel cell config registers, registered core output data,
// synchronised and optionally glitch-filtered pad inputs, sticky edge flags and a combined irq.
// Build option: define IO_BANK_FILTER_EN to include the per-channel glitch filter.
module io_bank_ctrl #(
  parameter int                      N_CH          = 8,
  parameter int                      IOCELL_CFG_W  = 3,
  parameter logic [IOCELL_CFG_W-1:0] RESET_CFG     = 3'b111,
  parameter int                      SYNC_STAGES   = 2,
  parameter int                      FILTER_CYCLES = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cfg_we,
  input  logic [$clog2(N_CH):0]          cfg_addr,
  input  logic [IOCELL_CFG_W-1:0]        cfg_wdata,
  output logic [IOCELL_CFG_W-1:0]        cfg_rdata,
  output logic                           cfg_err,
  input  logic [N_CH-1:0]                gpio_out,
  output logic [N_CH-1:0]                gpio_in,
  input  logic [N_CH-1:0]                irq_rise_en,
  input  logic [N_CH-1:0]                irq_fall_en,
  input  logic [N_CH-1:0]                status_clr,
  output logic [N_CH-1:0]                edge_status,
  output logic                           irq,
  output logic [N_CH*IOCELL_CFG_W-1:0]   cell_cfg,
  output logic [N_CH-1:0]                cell_from_core,
  input  logic [N_CH-1:0]                cell_to_core
);

  localparam int AW = $clog2(N_CH) + 1;

  if (N_CH < 1 || N_CH > 32 || SYNC_STAGES < 2 || FILTER_CYCLES < 1 || FILTER_CYCLES > 255) begin : g_param_check
    $error("io_bank_ctrl: parameter out of range");
  end

  logic [N_CH*IOCELL_CFG_W-1:0] cfg_q;
  logic [N_CH-1:0]              sync_q [SYNC_STAGES];
  logic [N_CH-1:0]              sync_out;
  logic [N_CH-1:0]              gpio_in_q;
  logic [N_CH-1:0]              edge_set;
  logic                         addr_ok;

  assign addr_ok  = (cfg_addr < AW'(N_CH));
  assign cell_cfg = cfg_q;
  assign sync_out = sync_q[SYNC_STAGES-1];

  always_comb begin
    cfg_rdata = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (cfg_addr == AW'(i)) cfg_rdata = cfg_q[i*IOCELL_CFG_W +: IOCELL_CFG_W];
    end
  end

  // Config and output data share one register stage so they reach the cell on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_q          <= {N_CH{RESET_CFG}};
      cfg_err        <= 1'b0;
      cell_from_core <= '0;
    end else begin
      cfg_err        <= cfg_we & ~addr_ok;
      cell_from_core <= gpio_out;
      for (int i = 0; i < N_CH; i++) begin
        if (cfg_we && cfg_addr == AW'(i)) cfg_q[i*IOCELL_CFG_W +: IOCELL_CFG_W] <= cfg_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= cell_to_core;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

`ifdef IO_BANK_FILTER_EN
  logic [7:0] flt_cnt [N_CH];

  // A new level is accepted only after FILTER_CYCLES consecutive cycles of disagreement.
  always_ff @(posedge clk) begin
    if (rst) begin
      gpio_in <= '0;
      for (int i = 0; i < N_CH; i++) flt_cnt[i] <= 8'd0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (sync_out[i] == gpio_in[i]) begin
          flt_cnt[i] <= 8'd0;
        end else if (flt_cnt[i] == 8'(FILTER_CYCLES - 1)) begin
          gpio_in[i] <= sync_out[i];
          flt_cnt[i] <= 8'd0;
        end else begin
          flt_cnt[i] <= flt_cnt[i] + 8'd1;
        end
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) gpio_in <= '0;
    else     gpio_in <= sync_out;
  end
`endif

  assign edge_set = (gpio_in & ~gpio_in_q & irq_rise_en) | (~gpio_in & gpio_in_q & irq_fall_en);

  // A new edge in the same cycle as its clear keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      gpio_in_q   <= '0;
      edge_status <= '0;
    end else begin
      gpio_in_q   <= gpio_in;
      edge_status <= (edge_status & ~status_clr) | edge_set;
    end
  end

  assign irq = |edge_status;

endmodule

// File: tb/tb_io_bank_ctrl.sv
// Bench for io_bank_ctrl: config table, hand-written edge/filter sequences and a random phase,
// all checked every cycle against a window-based behavioural model of the bank.
module tb_io_bank_ctrl;
  localparam int N_CH = 8;
  localparam int W    = 3;
  localparam int S    = 2;
  localparam int F    = 4;
`ifdef IO_BANK_FILTER_EN
  localparam int F_EFF = F;
`else
  localparam int F_EFF = 1;
`endif
  localparam int LAT = S + F_EFF;

  logic            clk = 1'b0;
  logic            rst;
  logic            cfg_we;
  logic [3:0]      cfg_addr;
  logic [W-1:0]    cfg_wdata;
  logic [W-1:0]    cfg_rdata;
  logic            cfg_err;
  logic [N_CH-1:0] gpio_out, gpio_in, irq_rise_en, irq_fall_en, status_clr, edge_status;
  logic            irq;
  logic [N_CH*W-1:0] cell_cfg;
  logic [N_CH-1:0] cell_from_core, cell_to_core;

  io_bank_ctrl #(
    .N_CH(N_CH), .IOCELL_CFG_W(W), .RESET_CFG(3'b111), .SYNC_STAGES(S), .FILTER_CYCLES(F)
  ) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_rdata(cfg_rdata), .cfg_err(cfg_err), .gpio_out(gpio_out), .gpio_in(gpio_in),
    .irq_rise_en(irq_rise_en), .irq_fall_en(irq_fall_en), .status_clr(status_clr),
    .edge_status(edge_status), .irq(irq), .cell_cfg(cell_cfg),
    .cell_from_core(cell_from_core), .cell_to_core(cell_to_core)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  logic [W-1:0]    m_cfg [N_CH];
  logic [N_CH-1:0] m_from, m_in, m_q, m_es;
  logic            m_err;
  logic [N_CH-1:0] pad_hist [$];
  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic         we;
    logic [3:0]   addr;
    logic [W-1:0] wdata;
    logic         exp_err;
    logic [W-1:0] exp_rd;
  } cfg_vec_t;
  cfg_vec_t tbl [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // gpio_in takes a level once the last F_EFF synchronised samples all agree on it.
  task automatic model_step();
    logic [N_CH-1:0] set, win_and, win_or;
    if (rst) begin
      for (int i = 0; i < N_CH; i++) m_cfg[i] = 3'b111;
      m_from = '0; m_in = '0; m_q = '0; m_es = '0; m_err = 1'b0;
      pad_hist.delete();
      repeat (S + F_EFF) pad_hist.push_back('0);
    end else begin
      m_err = cfg_we && (cfg_addr >= 4'(N_CH));
      if (cfg_we && cfg_addr < 4'(N_CH)) m_cfg[cfg_addr[2:0]] = cfg_wdata;
      m_from = gpio_out;
      set = (m_in & ~m_q & irq_rise_en) | (~m_in & m_q & irq_fall_en);
      m_es = (m_es & ~status_clr) | set;
      win_and = '1;
      win_or  = '0;
      for (int j = 0; j < F_EFF; j++) begin
        win_and &= pad_hist[pad_hist.size() - S - j];
        win_or  |= pad_hist[pad_hist.size() - S - j];
      end
      m_q  = m_in;
      m_in = win_and | (m_in & win_or);
      pad_hist.push_back(cell_to_core);
      if (pad_hist.size() > S + F_EFF) void'(pad_hist.pop_front());
    end
  endtask

  task automatic check_all();
    logic [N_CH*W-1:0] exp_cfg;
    logic [W-1:0]      exp_rd;
    for (int i = 0; i < N_CH; i++) exp_cfg[i*W +: W] = m_cfg[i];
    exp_rd = (cfg_addr < 4'(N_CH)) ? m_cfg[cfg_addr[2:0]] : '0;
    check("cell_cfg", 64'(cell_cfg), 64'(exp_cfg));
    check("cell_from_core", 64'(cell_from_core), 64'(m_from));
    check("gpio_in", 64'(gpio_in), 64'(m_in));
    check("edge_status", 64'(edge_status), 64'(m_es));
    check("irq", 64'(irq), 64'(|m_es));
    check("cfg_err", 64'(cfg_err), 64'(m_err));
    check("cfg_rdata", 64'(cfg_rdata), 64'(exp_rd));
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic wait_gpio(input int ch, input logic val);
    for (int k = 0; k < 30; k++) begin
      cycle();
      if (gpio_in[ch] === val) break;
    end
    check("wait_gpio", 64'(gpio_in[ch]), 64'(val));
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; gpio_out = '0;
    irq_rise_en = '0; irq_fall_en = '0; status_clr = '0; cell_to_core = '0;

    tbl[0] = '{1'b1, 4'd0,  3'b000, 1'b0, 3'b000};
    tbl[1] = '{1'b1, 4'd7,  3'b101, 1'b0, 3'b101};
    tbl[2] = '{1'b1, 4'd8,  3'b010, 1'b1, 3'b000};
    tbl[3] = '{1'b1, 4'd15, 3'b001, 1'b1, 3'b000};
    tbl[4] = '{1'b0, 4'd2,  3'b111, 1'b0, 3'b010};
    tbl[5] = '{1'b1, 4'd2,  3'b110, 1'b0, 3'b110};
    tbl[6] = '{1'b0, 4'd7,  3'b000, 1'b0, 3'b101};
    tbl[7] = '{1'b0, 4'd0,  3'b011, 1'b0, 3'b000};
    tbl[8] = '{1'b1, 4'd5,  3'b011, 1'b0, 3'b011};
    tbl[9] = '{1'b0, 4'd3,  3'b000, 1'b0, 3'b111};

    // Reset with pad0 held high throughout
    cell_to_core[0] = 1'b1;
    repeat (3) cycle();
    check("rst_cell_cfg", 64'(cell_cfg), 64'({8{3'b111}}));
    check("rst_gpio_in", 64'(gpio_in), 64'd0);
    check("rst_irq", 64'(irq), 64'd0);
    rst = 1'b0;
    repeat (LAT + 4) cycle();
    check("rst_no_edge", 64'(edge_status), 64'd0);
    cell_to_core[0] = 1'b0;
    wait_gpio(0, 1'b0);

    // Config write and output data landing on the same edge
    cfg_we = 1'b1; cfg_addr = 4'd2; cfg_wdata = 3'b010; gpio_out = 8'h04;
    cycle();
    check("wr_cfg_ch2", 64'(cell_cfg[8:6]), 64'(3'b010));
    check("wr_from_core2", 64'(cell_from_core[2]), 64'd1);
    cfg_addr = 4'd8; cfg_wdata = 3'b101;
    cycle();
    check("oor_err", 64'(cfg_err), 64'd1);
    check("oor_cell_cfg", 64'(cell_cfg), 64'(24'o77777277));
    check("oor_rdata", 64'(cfg_rdata), 64'd0);
    cfg_we = 1'b0;
    cycle();
    check("oor_err_pulse", 64'(cfg_err), 64'd0);

    for (int v = 0; v < 10; v++) begin
      cfg_we = tbl[v].we; cfg_addr = tbl[v].addr; cfg_wdata = tbl[v].wdata;
      cycle();
      check("tbl_err", 64'(cfg_err), 64'(tbl[v].exp_err));
      check("tbl_rdata", 64'(cfg_rdata), 64'(tbl[v].exp_rd));
    end
    cfg_we = 1'b0;

`ifdef IO_BANK_FILTER_EN
    // Glitch shorter than the filter window is dropped
    cell_to_core[1] = 1'b1;
    repeat (F - 1) cycle();
    cell_to_core[1] = 1'b0;
    for (int k = 0; k < LAT + 4; k++) begin
      cycle();
      check("glitch_blocked", 64'(gpio_in[1]), 64'd0);
    end
`else
    // Single-cycle pulse passes straight through the synchroniser
    cell_to_core[0] = 1'b1;
    cycle();
    cell_to_core[0] = 1'b0;
    for (int k = 2; k <= LAT + 1; k++) begin
      cycle();
      check("pulse_gpio0", 64'(gpio_in[0]), 64'(k == LAT));
    end
`endif

    // Clean 10-cycle pulse: latency from pad edge to gpio_in
    cell_to_core[1] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      cycle();
      if (k == LAT - 1) check("lat_before", 64'(gpio_in[1]), 64'd0);
      if (k == LAT)     check("lat_exact", 64'(gpio_in[1]), 64'd1);
    end
    cell_to_core[1] = 1'b0;
    wait_gpio(1, 1'b0);
    repeat (3) cycle();

    // Rising-edge flag, clear, and set-wins-over-clear
    irq_rise_en[1] = 1'b1;
    cell_to_core[1] = 1'b1;
    wait_gpio(1, 1'b1);
    cycle();
    check("rise_flag", 64'(edge_status[1]), 64'd1);
    check("rise_irq", 64'(irq), 64'd1);
    status_clr[1] = 1'b1;
    cycle();
    status_clr[1] = 1'b0;
    check("clr_flag", 64'(edge_status[1]), 64'd0);
    check("clr_irq", 64'(irq), 64'd0);
    cell_to_core[1] = 1'b0;
    wait_gpio(1, 1'b0);
    cell_to_core[1] = 1'b1;
    wait_gpio(1, 1'b1);
    status_clr[1] = 1'b1;
    cycle();
    status_clr[1] = 1'b0;
    check("set_wins", 64'(edge_status[1]), 64'd1);
    status_clr[1] = 1'b1;
    cycle();
    status_clr[1] = 1'b0;
    check("lone_clr", 64'(edge_status[1]), 64'd0);
    check("lone_clr_irq", 64'(irq), 64'd0);
    irq_rise_en = '0;

    // Falling edge only flagged when enabled
    cell_to_core[3] = 1'b1;
    wait_gpio(3, 1'b1);
    cell_to_core[3] = 1'b0;
    wait_gpio(3, 1'b0);
    repeat (3) cycle();
    check("fall_masked", 64'(edge_status[3]), 64'd0);
    irq_fall_en[3] = 1'b1;
    cell_to_core[3] = 1'b1;
    wait_gpio(3, 1'b1);
    cell_to_core[3] = 1'b0;
    wait_gpio(3, 1'b0);
    cycle();
    check("fall_flag", 64'(edge_status[3]), 64'd1);
    irq_fall_en = '0;

    // Random traffic against the model
    for (int r = 0; r < 500; r++) begin
      rst          = ($urandom_range(0, 59) == 0);
      cfg_we       = ($urandom_range(0, 3) == 0);
      cfg_addr     = 4'($urandom_range(0, 15));
      cfg_wdata    = W'($urandom);
      gpio_out     = N_CH'($urandom);
      irq_rise_en  = N_CH'($urandom);
      irq_fall_en  = N_CH'($urandom);
      status_clr   = N_CH'($urandom & $urandom & $urandom);
      cell_to_core = cell_to_core ^ N_CH'($urandom & $urandom & $urandom);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
